reset_sequencer: RTL and testbench



---
 rtl/reset_pkg.sv | 24 ++
 rtl/seq_counter.sv | 33 +++
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_reset_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
package reset_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_DELAY,
        S_ACK,
        S_DONE
    } seq_state_t;

    function automatic int ceil_log2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable, clearable up-counter with a terminal-count compare; one instance
// times the hold, inter-stage delay and ack-timeout phases in turn.
module seq_counter
    import reset_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] count,
    output logic         at_terminal
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in index order, spacing releases by a
// programmable delay and an init-done handshake; lock loss or sw request restarts.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 8,
    parameter int ACK_TIMEOUT = 1024,
    localparam int CNT_W = ceil_log2(max3(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT)) + 1,
    localparam int IDX_W = ceil_log2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lock,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_done,
    output logic                  timeout_err,
    output logic [IDX_W-1:0]      cur_stage
);

    localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

    seq_state_t            state, state_nxt;
    logic [NUM_STAGES-1:0] stage_nxt;
    logic                  done_nxt, terr_nxt;
    logic [IDX_W-1:0]      cur_nxt;
    logic                  cnt_clear, cnt_inc, cnt_at_term;
    logic [CNT_W-1:0]      cnt_value, cnt_terminal;
    logic                  restart, ack_sel;

    assign restart = !lock || sw_rst_req;
    assign ack_sel = stage_ack[cur_stage];

    seq_counter #(.W(CNT_W)) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .load       (1'b0),
        .load_value ('0),
        .inc        (cnt_inc),
        .terminal   (cnt_terminal),
        .count      (cnt_value),
        .at_terminal(cnt_at_term)
    );

    always_comb begin
        cnt_terminal = '0;
        unique case (state)
            S_HOLD:  cnt_terminal = CNT_W'(HOLD_CYCLES - 1);
            S_DELAY: cnt_terminal = CNT_W'(STAGE_DELAY - 1);
            S_ACK:   cnt_terminal = CNT_W'(ACK_TIMEOUT - 1);
            default: cnt_terminal = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_HOLD;
            stage_rst_n <= '0;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
            cur_stage   <= '0;
        end else begin
            state       <= state_nxt;
            stage_rst_n <= stage_nxt;
            seq_done    <= done_nxt;
            timeout_err <= terr_nxt;
            cur_stage   <= cur_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_HOLD: begin
                if (!restart && cnt_at_term) state_nxt = S_DELAY;
            end
            S_DELAY: begin
                if (restart)          state_nxt = S_HOLD;
                else if (cnt_at_term) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (restart)
                    state_nxt = S_HOLD;
                else if (ack_sel || cnt_at_term)
                    state_nxt = (cur_stage == LAST_STAGE) ? S_DONE : S_DELAY;
            end
            S_DONE: begin
                if (restart) state_nxt = S_HOLD;
            end
            default: state_nxt = S_HOLD;
        endcase
    end

    // Restart outside the hold phase wins over any release or ack on the same edge.
    always_comb begin
        stage_nxt = stage_rst_n;
        done_nxt  = seq_done;
        terr_nxt  = timeout_err;
        cur_nxt   = cur_stage;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        if (state != S_HOLD && restart) begin
            stage_nxt = '0;
            done_nxt  = 1'b0;
            cur_nxt   = '0;
            cnt_clear = 1'b1;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (restart) begin
                        cnt_clear = 1'b1;
                    end else if (cnt_at_term) begin
                        stage_nxt = NUM_STAGES'(1);
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (cnt_at_term) cnt_clear = 1'b1;
                    else             cnt_inc   = 1'b1;
                end
                S_ACK: begin
                    if (ack_sel || cnt_at_term) begin
                        cnt_clear = 1'b1;
                        if (!ack_sel) terr_nxt = 1'b1;
                        if (cur_stage == LAST_STAGE) begin
                            done_nxt = 1'b1;
                        end else begin
                            stage_nxt = {stage_rst_n[NUM_STAGES-2:0], 1'b1};
                            cur_nxt   = cur_stage + IDX_W'(1);
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a release-count / elapsed-time model of the sequencer.
module tb_reset_sequencer;

    localparam int N = 4;
    localparam int H = 16;
    localparam int D = 8;
    localparam int T = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lock = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic [N-1:0] stage_ack = '1;
    logic [N-1:0] stage_rst_n;
    logic         seq_done;
    logic         timeout_err;
    logic [1:0]   cur_stage;

    int           total = 0;
    int           bad = 0;
    logic [N-1:0] prev_stage = '0;

    reset_sequencer #(
        .NUM_STAGES (N),
        .HOLD_CYCLES(H),
        .STAGE_DELAY(D),
        .ACK_TIMEOUT(T)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lock       (lock),
        .sw_rst_req (sw_rst_req),
        .stage_ack  (stage_ack),
        .stage_rst_n(stage_rst_n),
        .seq_done   (seq_done),
        .timeout_err(timeout_err),
        .cur_stage  (cur_stage)
    );

    always #5 clk = ~clk;

    // Model: how many stages are out of reset, consecutive good hold edges,
    // and edges elapsed since the most recent release.
    typedef struct packed {
        int rel;
        int hold_run;
        int since;
        bit done;
        bit terr;
    } model_t;

    model_t m = '0;

    function automatic model_t model_step(input model_t s, input logic rn, input logic lk,
                                          input logic sw, input logic [N-1:0] ack);
        model_t r;
        int     k;
        r = s;
        if (!rn) begin
            r = '0;
        end else if (r.rel == 0) begin
            if (!lk || sw) begin
                r.hold_run = 0;
            end else if (r.hold_run == H - 1) begin
                r.rel      = 1;
                r.hold_run = 0;
                r.since    = 0;
            end else begin
                r.hold_run = r.hold_run + 1;
            end
        end else if (!lk || sw) begin
            r.rel      = 0;
            r.hold_run = 0;
            r.done     = 1'b0;
        end else if (!r.done) begin
            k = r.since + 1;
            if (k >= D + 1 && (ack[r.rel-1] || k == D + T)) begin
                if (!ack[r.rel-1]) r.terr = 1'b1;
                if (r.rel < N) r.rel = r.rel + 1;
                else           r.done = 1'b1;
                r.since = 0;
            end else begin
                r.since = k;
            end
        end
        return r;
    endfunction

    always @(posedge clk) m <= model_step(m, rst_n, lock, sw_rst_req, stage_ack);

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0] s;
        logic [N-1:0] exp_stage;
        s         = stage_rst_n;
        exp_stage = N'((1 << m.rel) - 1);
        compare("stage_rst_n", 32'(s), 32'(exp_stage));
        compare("seq_done", 32'(seq_done), 32'(m.done));
        compare("timeout_err", 32'(timeout_err), 32'(m.terr));
        compare("cur_stage", 32'(cur_stage), (m.rel == 0) ? 32'd0 : 32'(m.rel - 1));
        compare("inv_thermometer", 32'((s & (s + 1'b1)) == '0), 32'd1);
        compare("inv_monotonic", 32'(((prev_stage & ~s) == '0) || (s == '0)), 32'd1);
        compare("inv_done_all_ones", 32'(!seq_done || (s == '1)), 32'd1);
        prev_stage = s;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput();
        end
    endtask

    task automatic expectLit(input string name, input logic [N-1:0] st, input logic dn,
                             input logic te, input logic [1:0] cs);
        compare({name, ".stage"}, 32'(stage_rst_n), 32'(st));
        compare({name, ".done"}, 32'(seq_done), 32'(dn));
        compare({name, ".terr"}, 32'(timeout_err), 32'(te));
        compare({name, ".cur"}, 32'(cur_stage), 32'(cs));
    endtask

    task automatic applyStimulus(input int cycles, input bit calm);
        repeat (cycles) begin
            rst_n      = calm ? ($urandom_range(0, 999) != 0) : ($urandom_range(0, 299) != 0);
            lock       = calm ? ($urandom_range(0, 799) != 0) : ($urandom_range(0, 149) != 0);
            sw_rst_req = calm ? ($urandom_range(0, 599) == 0) : ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) stage_ack[i] = ~stage_ack[i];
            tick(1);
        end
    endtask

    initial begin
        tick(2);
        expectLit("reset", 4'b0000, 1'b0, 1'b0, 2'd0);

        // Scenario 1: all acks high, nominal release timeline.
        rst_n = 1'b1;
        tick(15); expectLit("s1_pre0", 4'b0000, 1'b0, 1'b0, 2'd0);
        tick(1);  expectLit("s1_rel0", 4'b0001, 1'b0, 1'b0, 2'd0);
        tick(8);  expectLit("s1_pre1", 4'b0001, 1'b0, 1'b0, 2'd0);
        tick(1);  expectLit("s1_rel1", 4'b0011, 1'b0, 1'b0, 2'd1);
        tick(9);  expectLit("s1_rel2", 4'b0111, 1'b0, 1'b0, 2'd2);
        tick(9);  expectLit("s1_rel3", 4'b1111, 1'b0, 1'b0, 2'd3);
        tick(8);  expectLit("s1_predone", 4'b1111, 1'b0, 1'b0, 2'd3);
        tick(1);  expectLit("s1_done", 4'b1111, 1'b1, 1'b0, 2'd3);

        // Scenario 2: stage 1 never acks, forcing a timeout.
        rst_n = 1'b0; stage_ack = 4'b1101;
        tick(1);  expectLit("s2_reset", 4'b0000, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick(16); expectLit("s2_rel0", 4'b0001, 1'b0, 1'b0, 2'd0);
        tick(9);  expectLit("s2_rel1", 4'b0011, 1'b0, 1'b0, 2'd1);
        stage_ack = 4'b1001;
        tick(39); expectLit("s2_wait", 4'b0011, 1'b0, 1'b0, 2'd1);
        tick(1);  expectLit("s2_timeout", 4'b0111, 1'b0, 1'b1, 2'd2);

        // Scenario 3: one-cycle lock loss while waiting on stage 2.
        tick(12);
        lock = 1'b0;
        tick(1);  expectLit("s3_restart", 4'b0000, 1'b0, 1'b1, 2'd0);
        lock = 1'b1;
        tick(15); expectLit("s3_hold", 4'b0000, 1'b0, 1'b1, 2'd0);
        tick(1);  expectLit("s3_rel0", 4'b0001, 1'b0, 1'b1, 2'd0);

        // Scenario 4: sw request on the same edge as stage 0 ack.
        stage_ack = 4'b0000;
        tick(11);
        stage_ack = 4'b0001; sw_rst_req = 1'b1;
        tick(1);  expectLit("s4_restart", 4'b0000, 1'b0, 1'b1, 2'd0);
        sw_rst_req = 1'b0;
        tick(15); expectLit("s4_hold", 4'b0000, 1'b0, 1'b1, 2'd0);
        tick(1);  expectLit("s4_rel0", 4'b0001, 1'b0, 1'b1, 2'd0);

        // Scenario 5: lock keeps dropping before the hold completes.
        lock = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            lock = 1'b1; tick(9);
            lock = 1'b0; tick(1);
            expectLit("s5_lockdrop", 4'b0000, 1'b0, 1'b1, 2'd0);
        end
        lock = 1'b1;
        tick(15); expectLit("s5_hold", 4'b0000, 1'b0, 1'b1, 2'd0);
        tick(1);  expectLit("s5_rel0", 4'b0001, 1'b0, 1'b1, 2'd0);

        // Scenario 6: rst_n mid-sequence clears the sticky error.
        stage_ack = '1;
        tick(20); expectLit("s6_mid", 4'b0111, 1'b0, 1'b1, 2'd2);
        rst_n = 1'b0;
        tick(1);  expectLit("s6_reset", 4'b0000, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;

        applyStimulus(2000, 1'b0);
        applyStimulus(2000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
